// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcode constants, load/store size codes and FSM states shared by the memory stage.
package mem_stage_pkg;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;
  typedef enum logic {IDLE, WAIT} state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane steering, byte enables, load extraction/extension and access legality.
// Sub-word accesses only with MEM_STAGE_SUBWORD_EN; otherwise every access is full width.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  offset,
  input  logic              is_store,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext,
  output logic [NB-1:0]     be,
  output logic              legal
);
`ifdef MEM_STAGE_SUBWORD_EN
  localparam int IW = $clog2(DATA_W);
  funct3_e f3;
  logic legal_f3;
  logic sign;
  logic [DATA_W-1:0] shifted;
  assign f3 = funct3_e'(funct3);
  assign legal_f3 = is_store ? (f3 inside {F3_B, F3_H, F3_W} || (f3 == F3_D && DATA_W == 64))
                             : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} ||
                                (f3 inside {F3_WU, F3_D} && DATA_W == 64));
  assign shifted = rdata >> {offset, 3'b000};
  always_comb begin
    int sz;
    int bits;
    int off;
    sz = 1 << funct3[1:0];
    bits = 8 * sz;
    off = int'(offset);
    legal = legal_f3 && ((off & (sz - 1)) == 0);
    sign = !funct3[2] && shifted[IW'((bits > DATA_W ? DATA_W : bits) - 1)];
    for (int j = 0; j < DATA_W; j++) rdata_ext[j] = (j < bits) ? shifted[j] : sign;
    for (int i = 0; i < NB; i++) begin
      wdata_lane[8*i +: 8] = funct3[1:0] == 2'd0 ? wdata[7:0] :
                             funct3[1:0] == 2'd1 ? wdata[8*(i%2) +: 8] :
                             funct3[1:0] == 2'd2 ? wdata[8*(i%4) +: 8] : wdata[8*i +: 8];
      be[i] = is_store && legal && i >= off && i < off + sz;
    end
  end
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
  assign legal = offset == '0;
  assign wdata_lane = wdata;
  assign rdata_ext = rdata;
  assign be = is_store ? '1 : '0;
`endif
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store/pass-through pipeline stage with a two-state memory handshake FSM.
// Define MEM_STAGE_SUBWORD_EN for byte/halfword/word accesses; default is full-width only.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic [OP_W-1:0]     opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                ready_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                valid_o,
  output logic [OP_W-1:0]     opcode_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                misalign_o
);
  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  state_e state, state_d;
  logic in_wait, is_load, is_store, is_mem, legal, hit, mem_req;
  logic valid_d, misalign_d;
  logic [OP_W-1:0] opcode_q, cur_op, opcode_d;
  logic [2:0] funct3_q, cur_f3;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [DATA_W-1:0] wdata_q, cur_wdata, rdata_ext, data_d;
  // While waiting, the access is replayed from the captured copy so upstream may change freely.
  assign in_wait = state == WAIT;
  assign cur_op = in_wait ? opcode_q : opcode_i;
  assign cur_f3 = in_wait ? funct3_q : funct3_i;
  assign cur_addr = in_wait ? addr_q : addr_i;
  assign cur_wdata = in_wait ? wdata_q : wdata_i;
  assign is_load = cur_op == OP_W'(OP_LOAD);
  assign is_store = cur_op == OP_W'(OP_STORE);
  assign is_mem = is_load || is_store;
  assign hit = is_mem && legal;
  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (cur_f3),
    .offset     (cur_addr[OFF_W-1:0]),
    .is_store   (is_store),
    .wdata      (cur_wdata),
    .rdata      (mem_rdata_i),
    .wdata_lane (mem_wdata_o),
    .rdata_ext  (rdata_ext),
    .be         (mem_be_o),
    .legal      (legal)
  );
  assign mem_addr_o = {cur_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_req_o = mem_req && rst_n;
  assign mem_we_o = mem_req_o && is_store;
  always_comb begin
    state_d = state;
    valid_d = 1'b0;
    opcode_d = opcode_o;
    data_d = data_o;
    misalign_d = 1'b0;
    mem_req = 1'b0;
    ready_o = 1'b0;
    if (in_wait) begin
      mem_req = 1'b1;
      if (mem_ready_i) begin
        state_d = IDLE;
        valid_d = 1'b1;
        opcode_d = opcode_q;
        data_d = is_load ? rdata_ext : '0;
      end
    end else begin
      ready_o = !(valid_i && hit && !mem_ready_i);
      if (valid_i) begin
        mem_req = hit;
        state_d = (hit && !mem_ready_i) ? WAIT : IDLE;
        if (!hit || mem_ready_i) begin
          valid_d = 1'b1;
          opcode_d = opcode_i;
          misalign_d = is_mem && !legal;
          data_d = !is_mem ? DATA_W'(addr_i) : (is_load && legal) ? rdata_ext : '0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid_o <= 1'b0;
      opcode_o <= '0;
      data_o <= '0;
      misalign_o <= 1'b0;
      opcode_q <= '0;
      funct3_q <= 3'b000;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      valid_o <= valid_d;
      opcode_o <= opcode_d;
      data_o <= data_d;
      misalign_o <= misalign_d;
      if (!in_wait) begin
        opcode_q <= opcode_i;
        funct3_q <= funct3_i;
        addr_q <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data path width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-003 The block SHALL have parameter OP_W, default 5, opcode width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have inputs valid_i (1), opcode_i (OP_W), funct3_i (3), addr_i (ADDR_W, ALU result), wdata_i (DATA_W, store data).
REQ-007 The block SHALL have output ready_o (1), the upstream accept; 0 stalls the stage feeding it.
REQ-008 The block SHALL have outputs mem_req_o (1), mem_we_o (1), mem_addr_o (ADDR_W), mem_wdata_o (DATA_W) and mem_be_o (DATA_W/8) toward data memory.
REQ-009 The block SHALL have inputs mem_ready_i (1), memory access complete, and mem_rdata_i (DATA_W).
REQ-010 The block SHALL have registered outputs valid_o (1), opcode_o (OP_W), data_o (DATA_W) and misalign_o (1) toward writeback.

Function
REQ-011 Opcode 5'b00000 SHALL be load, 5'b01000 SHALL be store, and every other opcode SHALL be pass-through.
REQ-012 The FSM SHALL have two states, IDLE and WAIT.
REQ-013 In IDLE with valid_i=1 and an aligned load/store, mem_req_o SHALL be 1 combinationally in the same cycle, with mem_addr_o equal to addr_i rounded down to a DATA_W/8 boundary.
REQ-014 If mem_ready_i=1 in the request cycle, the result SHALL be registered at that edge and the FSM SHALL remain IDLE with ready_o=1.
REQ-015 If mem_ready_i=0 in the request cycle, the FSM SHALL go to WAIT and ready_o SHALL be 0.
REQ-016 In WAIT, the request SHALL be held stable from internal registers, ignoring inputs, until mem_ready_i=1; the FSM SHALL then capture the result and return to IDLE.
REQ-017 Latency SHALL be 1 cycle for pass-through and for zero-wait accesses, and 1+N cycles for N wait cycles.
REQ-018 A pass-through op SHALL set opcode_o=opcode_i and data_o=addr_i at the next edge, with valid_o=1 and no memory request.
REQ-019 Loads SHALL decode funct3: 000 LB and 100 LBU extract a byte; 001 LH and 101 LHU a halfword; 010 LW a word; 110 LWU and 011 LD are valid only when DATA_W=64.
REQ-020 Loads SHALL select the lane from the low address bits and sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to DATA_W.
REQ-021 Stores SHALL replicate wdata_i's low bytes across all lanes and set mem_be_o to the accessed lanes; SB to address 0x...2 SHALL give mem_be_o=4'b0100.
REQ-022 mem_we_o SHALL be 1 only for stores, and mem_be_o SHALL be all zeros for loads.
REQ-023 An access not naturally aligned to its size, or with an illegal funct3, SHALL issue no request and SHALL set valid_o=1, misalign_o=1, data_o=0 at the next edge.
REQ-024 When valid_i=0 in IDLE, valid_o SHALL be 0 at the next edge and opcode_o/data_o SHALL hold their previous values.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE and valid_o, opcode_o, data_o and misalign_o SHALL be 0.
REQ-026 While rst_n=0, mem_req_o and mem_we_o SHALL be forced to 0 regardless of inputs.
REQ-027 A reset asserted in WAIT SHALL abandon the access, and the late mem_ready_i after release SHALL be ignored.

Configuration
REQ-028 With macro MEM_STAGE_SUBWORD_EN defined, REQ-019 to REQ-021 SHALL apply.
REQ-029 Without MEM_STAGE_SUBWORD_EN, funct3_i SHALL be ignored and every access SHALL be full-width, with mem_be_o all ones; misalignment SHALL be checked against DATA_W/8 only.

Structure
REQ-030 Package mem_stage_pkg SHALL hold the opcode constants (OP_LOAD, OP_STORE), the funct3 enum and the state enum.
REQ-031 Sub-module mem_lane_align SHALL be combinational and SHALL hold the store lane steering, the byte-enable generation, and the load extraction and extension.

Verification
REQ-032 LW at 0x100 with mem_ready_i=1 in the same cycle and rdata 0xDEADBEEF -> next cycle valid_o=1, data_o=0xDEADBEEF.
REQ-033 LB at 0x103 with rdata 0x80FFFFFF -> data_o=0xFFFFFF80; LBU at the same address -> data_o=0x00000080.
REQ-034 SH at 0x102 with wdata 0x1234ABCD -> mem_wdata_o=0xABCDABCD, mem_be_o=4'b1100, mem_we_o=1.
REQ-035 LW with mem_ready_i held 0 for 3 cycles -> ready_o=0 for 3 cycles, request stable, result 4 cycles after issue.
REQ-036 LH at 0x101 -> mem_req_o stays 0 and next cycle misalign_o=1, data_o=0; rst_n pulsed in WAIT -> mem_req_o=0 immediately and all outputs 0.
